// File: rtl/id_ex_stage_if.sv
// Bundle of decode, forwarding and EX-side signals exchanged with the ID/EX register.
// The master drives decode and forwarding inputs; the slave is the stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [DATA_W-1:0] id_rs_val_i;
    logic [DATA_W-1:0] id_rt_val_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_uses_rt_i;
    logic [DATA_W-1:0] id_imm_i;
    logic              id_alu_src_i;
    logic [3:0]        id_alu_ctrl_i;
    logic              id_reg_write_i;
    logic              id_mem_read_i;
    logic              id_mem_write_i;
    logic              id_mem_to_reg_i;
    logic              flush_i;
    logic              exm_reg_write_i;
    logic [REG_AW-1:0] exm_rd_i;
    logic [DATA_W-1:0] exm_result_i;
    logic              mwb_reg_write_i;
    logic [REG_AW-1:0] mwb_rd_i;
    logic [DATA_W-1:0] mwb_result_i;
    logic              stall_o;
    logic              ex_valid_o;
    logic [DATA_W-1:0] src1_o;
    logic [DATA_W-1:0] src2_o;
    logic [3:0]        ALU_control_o;
    logic [DATA_W-1:0] ex_rt_fwd_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              ex_reg_write_o;
    logic              ex_mem_read_o;
    logic              ex_mem_write_o;
    logic              ex_mem_to_reg_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_valid_i, id_rs_val_i, id_rt_val_i, id_rs_i, id_rt_i, id_rd_i,
               id_uses_rt_i, id_imm_i, id_alu_src_i, id_alu_ctrl_i,
               id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
               flush_i, exm_reg_write_i, exm_rd_i, exm_result_i,
               mwb_reg_write_i, mwb_rd_i, mwb_result_i,
        input  stall_o, ex_valid_o, src1_o, src2_o, ALU_control_o, ex_rt_fwd_o,
               ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
               ex_mem_to_reg_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_val_i, id_rt_val_i, id_rs_i, id_rt_i, id_rd_i,
               id_uses_rt_i, id_imm_i, id_alu_src_i, id_alu_ctrl_i,
               id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
               flush_i, exm_reg_write_i, exm_rd_i, exm_result_i,
               mwb_reg_write_i, mwb_rd_i, mwb_result_i,
        output stall_o, ex_valid_o, src1_o, src2_o, ALU_control_o, ex_rt_fwd_o,
               ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
               ex_mem_to_reg_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection,
// branch flush handling and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic              valid_q;
    logic [DATA_W-1:0] rs_val_q;
    logic [DATA_W-1:0] rt_val_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic [3:0]        alu_ctrl_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic              stall;
    logic              bubble;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] s,
        input logic [DATA_W-1:0] reg_val,
        input logic              exm_we,
        input logic [REG_AW-1:0] exm_rd,
        input logic [DATA_W-1:0] exm_res,
        input logic              mwb_we,
        input logic [REG_AW-1:0] mwb_rd,
        input logic [DATA_W-1:0] mwb_res
    );
        if (exm_we && exm_rd != '0 && exm_rd == s)
            return exm_res;
        else if (mwb_we && mwb_rd != '0 && mwb_rd == s)
            return mwb_res;
        else
            return reg_val;
    endfunction

    assign stall = ~bus.flush_i & bus.id_valid_i & valid_q & mem_read_q & (rd_q != '0) &
                   ((rd_q == bus.id_rs_i) | (bus.id_uses_rt_i & (rd_q == bus.id_rt_i)));
    assign bubble = bus.flush_i | stall;

    assign rs_fwd = fwd(rs_q, rs_val_q, bus.exm_reg_write_i, bus.exm_rd_i, bus.exm_result_i,
                        bus.mwb_reg_write_i, bus.mwb_rd_i, bus.mwb_result_i);
    assign rt_fwd = fwd(rt_q, rt_val_q, bus.exm_reg_write_i, bus.exm_rd_i, bus.exm_result_i,
                        bus.mwb_reg_write_i, bus.mwb_rd_i, bus.mwb_result_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            valid_q      <= 1'b0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= bus.id_valid_i;
            rs_val_q     <= bus.id_rs_val_i;
            rt_val_q     <= bus.id_rt_val_i;
            rs_q         <= bus.id_rs_i;
            rt_q         <= bus.id_rt_i;
            rd_q         <= bus.id_rd_i;
            imm_q        <= bus.id_imm_i;
            alu_src_q    <= bus.id_alu_src_i;
            alu_ctrl_q   <= bus.id_alu_ctrl_i;
            // An invalid slot must never write state downstream.
            reg_write_q  <= bus.id_reg_write_i  & bus.id_valid_i;
            mem_read_q   <= bus.id_mem_read_i   & bus.id_valid_i;
            mem_write_q  <= bus.id_mem_write_i  & bus.id_valid_i;
            mem_to_reg_q <= bus.id_mem_to_reg_i & bus.id_valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (bus.flush_i && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_o         = stall;
    assign bus.ex_valid_o      = valid_q;
    assign bus.src1_o          = rs_fwd;
    assign bus.ex_rt_fwd_o     = rt_fwd;
    assign bus.src2_o          = alu_src_q ? imm_q : rt_fwd;
    assign bus.ALU_control_o   = alu_ctrl_q;
    assign bus.ex_rd_o         = rd_q;
    assign bus.ex_reg_write_o  = reg_write_q;
    assign bus.ex_mem_read_o   = mem_read_q;
    assign bus.ex_mem_write_o  = mem_write_q;
    assign bus.ex_mem_to_reg_o = mem_to_reg_q;
    assign bus.stall_cnt_o     = stall_cnt_q;
    assign bus.flush_cnt_o     = flush_cnt_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined CPU. Registers the decoded instruction bundle each cycle.
- Resolves operand forwarding from EX/MEM and MEM/WB and drives the ALU inputs: src1, src2, ALU_control.
- Detects load-use hazards and requests a front-end stall; accepts branch flushes from the EX stage.
- Provides saturating stall/flush event counters for performance debug.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- id_valid_i  input  1  decode holds a valid instruction
- id_rs_val_i  input  DATA_W  register-file read value of rs
- id_rt_val_i  input  DATA_W  register-file read value of rt
- id_rs_i  input  REG_AW  rs index
- id_rt_i  input  REG_AW  rt index
- id_rd_i  input  REG_AW  destination index, already selected by decode
- id_uses_rt_i  input  1  instruction reads rt as a register
- id_imm_i  input  DATA_W  sign-extended immediate
- id_alu_src_i  input  1  1 = src2 takes the immediate
- id_alu_ctrl_i  input  4  ALU control code
- id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i  input  1 each  control bits
- flush_i  input  1  branch taken; kill the instruction in decode
- exm_reg_write_i  input  1  EX/MEM forwarding write-enable
- exm_rd_i  input  REG_AW  EX/MEM forwarding destination
- exm_result_i  input  DATA_W  EX/MEM forwarding data
- mwb_reg_write_i  input  1  MEM/WB forwarding write-enable
- mwb_rd_i  input  REG_AW  MEM/WB forwarding destination
- mwb_result_i  input  DATA_W  MEM/WB forwarding data
- stall_o  output  1  hold PC and IF/ID this cycle
- ex_valid_o  output  1  EX stage holds a valid instruction
- src1_o  output  DATA_W  ALU source 1
- src2_o  output  DATA_W  ALU source 2
- ALU_control_o  output  4  ALU control code
- ex_rt_fwd_o  output  DATA_W  forwarded rt value (store data)
- ex_rd_o  output  REG_AW  registered destination index
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o  output  1 each  registered control bits
- stall_cnt_o  output  CNT_W  count of stall cycles
- flush_cnt_o  output  CNT_W  count of flush cycles

Behaviour:
- Reset: all registered fields clear to 0 immediately on rst rising, independent of clk. All outputs read 0 while rst is high, including both counters.
- Hazard (combinational): stall_o = ~flush_i & id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o!=0) & ((ex_rd_o==id_rs_i) | (id_uses_rt_i & ex_rd_o==id_rt_i)).
- Next-state priority at each clk edge:
  - flush_i: insert a bubble.
  - else stall_o: insert a bubble. Decode holds its own inputs; that is not handled here.
  - else capture the full id_* bundle, with ex_valid = id_valid_i.
- Bubble: every registered field is 0, including valid, controls, indices, values and immediate.
- If id_valid_i=0 on a capture, all four control bits are registered as 0.
- Forwarding (combinational from registered state and forward buses), per source index s = rs_q or rt_q:
  - If exm_reg_write_i & exm_rd_i!=0 & exm_rd_i==s, use exm_result_i.
  - Else if mwb_reg_write_i & mwb_rd_i!=0 & mwb_rd_i==s, use mwb_result_i.
  - Else use the registered value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Output mapping:
  - src1_o = fwd(rs).
  - ex_rt_fwd_o = fwd(rt).
  - src2_o = alu_src_q ? imm_q : fwd(rt).
  - ALU_control_o, ex_rd_o and control outputs are the registered values.
- Latency: 1 cycle from decode to EX outputs. Forwarding adds 0 cycles.
- Same-cycle register-file write-before-read is provided by the register file, not by this block.
- stall_cnt_o: +1 on each clk edge where stall_o=1; saturates at all-ones.
- flush_cnt_o: +1 on each clk edge where flush_i=1; saturates at all-ones.
- flush_i and a load-use condition together: flush wins, stall_o=0, only flush_cnt increments.

Test Plan:
- Reset mid-stream: valid add in EX, assert rst between edges -> ex_valid_o, src1_o, src2_o, ALU_control_o and both counters are 0 before the next edge. They stay 0 until the first capture after rst drops.
- Forward priority: EX holds rs=$3 with stale 0. exm_rd=3 data 0x10 and mwb_rd=3 data 0x20, both write-enabled -> src1_o=0x10. Drop exm_reg_write_i -> src1_o=0x20.
- Register zero: rs=$0, exm_rd=0, write-enabled, data 0xDEAD -> src1_o=0.
- Load-use: lw $5 in EX (mem_read=1, rd=5), decode add rs=$5 valid -> stall_o=1. Next edge: ex_valid_o=0, stall_cnt_o=1. Following edge: add captured, stall_o=0.
- Flush with hazard: same setup plus flush_i=1 -> stall_o=0. Next edge: bubble, flush_cnt_o=1, stall_cnt_o unchanged.
- Immediate select: alu_src=1, imm=0xFFFFFFFC, rt=$2 with mwb forward 0x7 -> src2_o=0xFFFFFFFC, ex_rt_fwd_o=0x7.
